// File: rtl/pwm_deadband.sv
// pwm_deadband: dead-time generator and gate drive for a two-leg H-bridge with latched fault shutdown
module pwm_deadband #(
    parameter int DEAD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DEAD_W-1:0] dead_time,
    input  logic              pwm_1,
    input  logic              pwm_2,
    input  logic              fault_n,
    input  logic              clr_fault,
    output logic              hi_1,
    output logic              lo_1,
    output logic              hi_2,
    output logic              lo_2,
    output logic              fault
);
    typedef enum logic [1:0] {S_OFF, S_DEAD, S_HI, S_LO} state_t;

    logic              en_q;
    logic [1:0]        pwm_q;
    logic [1:0]        fault_sync;
    logic [1:0]        hi;
    logic [1:0]        lo;
    logic [DEAD_W-1:0] d_load;

    // A zero dead band would allow a direct handover, so it is stretched to one cycle.
    assign d_load = (dead_time == '0) ? DEAD_W'(1) : dead_time;

    // Register enable and commands; two-flop synchronizer for the asynchronous fault input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            pwm_q      <= 2'b00;
            fault_sync <= 2'b11;
        end else begin
            en_q       <= en;
            pwm_q      <= {pwm_2, pwm_1};
            fault_sync <= {fault_sync[0], fault_n};
        end
    end

    // Fault latch: an active fault always beats a simultaneous clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fault <= 1'b0;
        else if (!fault_sync[1]) fault <= 1'b1;
        else if (clr_fault)      fault <= 1'b0;
    end

    for (genvar g = 0; g < 2; g++) begin : g_leg
        state_t            state, state_nx;
        logic              target, target_nx;
        logic [DEAD_W-1:0] cnt, cnt_nx;
        logic              hi_q, lo_q;

        // Leg state, dead counter and gate flops decoded from the next state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= S_OFF;
                target <= 1'b0;
                cnt    <= '0;
                hi_q   <= 1'b0;
                lo_q   <= 1'b0;
            end else begin
                state  <= state_nx;
                target <= target_nx;
                cnt    <= cnt_nx;
                hi_q   <= (state_nx == S_HI);
                lo_q   <= (state_nx == S_LO);
            end
        end

        // Next state: every path into a gate-on state waits a full dead band in S_DEAD.
        always_comb begin
            state_nx  = state;
            target_nx = target;
            cnt_nx    = cnt;
            if (!en_q || fault) begin
                state_nx = S_OFF;
            end else begin
                case (state)
                    S_OFF: begin
                        state_nx  = S_DEAD;
                        target_nx = pwm_q[g];
                        cnt_nx    = d_load;
                    end
                    S_DEAD: begin
                        if (pwm_q[g] != target) begin
                            target_nx = pwm_q[g];
                            cnt_nx    = d_load;
                        end else if (cnt == DEAD_W'(1)) begin
                            state_nx = target ? S_HI : S_LO;
                        end else begin
                            cnt_nx = cnt - DEAD_W'(1);
                        end
                    end
                    S_HI: begin
                        if (!pwm_q[g]) begin
                            state_nx  = S_DEAD;
                            target_nx = 1'b0;
                            cnt_nx    = d_load;
                        end
                    end
                    S_LO: begin
                        if (pwm_q[g]) begin
                            state_nx  = S_DEAD;
                            target_nx = 1'b1;
                            cnt_nx    = d_load;
                        end
                    end
                    default: state_nx = S_OFF;
                endcase
            end
        end

        assign hi[g] = hi_q;
        assign lo[g] = lo_q;
    end

    assign hi_1 = hi[0];
    assign lo_1 = lo[0];
    assign hi_2 = hi[1];
    assign lo_2 = lo[1];
endmodule

// File: tb/tb_pwm_deadband.sv
// tb_pwm_deadband: directed self-checking bench for the dead-time gate driver
module tb_pwm_deadband;
    logic       clk = 1'b0;
    logic       rst_n, en, pwm_1, pwm_2, fault_n, clr_fault;
    logic [7:0] dead_time;
    logic       hi_1, lo_1, hi_2, lo_2, fault;
    int         checks = 0;
    int         failures = 0;

    pwm_deadband #(.DEAD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dead_time(dead_time),
        .pwm_1(pwm_1), .pwm_2(pwm_2), .fault_n(fault_n), .clr_fault(clr_fault),
        .hi_1(hi_1), .lo_1(lo_1), .hi_2(hi_2), .lo_2(lo_2), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Gates of one leg must never be on together.
    always @(negedge clk) begin
        check("overlap_1", int'(hi_1 & lo_1), 0);
        check("overlap_2", int'(hi_2 & lo_2), 0);
    end

    // Toggle leg 1 and expect: old gate for one cycle, d cycles of both off, then the new gate.
    task automatic leg1_edge(input logic v, input int d);
        pwm_1 = v;
        for (int k = 1; k <= d + 2; k++) begin
            @(negedge clk);
            check("leg1_edge", int'({hi_1, lo_1}), k == 1 ? (v ? 1 : 2) : (k == d + 2 ? (v ? 2 : 1) : 0));
        end
        repeat (18 - d) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pwm_1 = 1'b0; pwm_2 = 1'b0;
        fault_n = 1'b1; clr_fault = 1'b0; dead_time = 8'd4;
        repeat (3) @(negedge clk);
        check("rst_gates", int'({hi_1, lo_1, hi_2, lo_2}), 0);
        check("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Enable with leg 1 high, leg 2 low, dead band 4: gates at 1+4 edges after EN sampled.
        en = 1'b1; pwm_1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("en_hi1", int'({hi_1, lo_1}), k == 6 ? 2 : 0);
            check("en_lo2", int'({hi_2, lo_2}), k == 6 ? 1 : 0);
        end
        repeat (4) @(negedge clk);

        // Periodic toggling with dead band 3.
        dead_time = 8'd3;
        leg1_edge(1'b0, 3);
        leg1_edge(1'b1, 3);
        leg1_edge(1'b0, 3);
        leg1_edge(1'b1, 3);

        // Zero dead band behaves as one cycle.
        dead_time = 8'd0;
        leg1_edge(1'b0, 1);
        leg1_edge(1'b1, 1);

        // Two-cycle high glitch on leg 2 while in LO with dead band 5.
        dead_time = 8'd5;
        pwm_2 = 1'b1;
        @(negedge clk);
        check("glitch_k0", int'({hi_2, lo_2}), 1);
        @(negedge clk);
        check("glitch_dead", int'({hi_2, lo_2}), 0);
        pwm_2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("glitch_ret", int'({hi_2, lo_2}), k == 7 ? 1 : 0);
        end
        check("glitch_leg1", int'({hi_1, lo_1}), 2);

        // Fault mid-HI: flag two edges after sampling, gates off one edge later.
        fault_n = 1'b0;
        @(negedge clk);
        check("flt_e1", int'(fault), 0);
        @(negedge clk);
        check("flt_e2", int'(fault), 0);
        check("flt_e2_hi", int'(hi_1), 1);
        @(negedge clk);
        check("flt_e3", int'(fault), 1);
        check("flt_e3_hi", int'(hi_1), 1);
        @(negedge clk);
        check("flt_off", int'({hi_1, lo_1, hi_2, lo_2}), 0);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        check("clr_blocked", int'(fault), 1);
        check("clr_blk_gates", int'({hi_1, lo_1, hi_2, lo_2}), 0);
        fault_n = 1'b1;
        repeat (2) @(negedge clk);
        check("flt_held", int'(fault), 1);
        clr_fault = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            clr_fault = 1'b0;
            if (k == 1) check("clr_ok", int'(fault), 0);
            check("clr_leg1", int'({hi_1, lo_1}), k == 7 ? 2 : 0);
            check("clr_leg2", int'({hi_2, lo_2}), k == 7 ? 1 : 0);
        end

        // Asynchronous reset while leg 1 is in DEAD with cnt = 2.
        dead_time = 8'd4;
        pwm_1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("pre_rst", int'({hi_1, lo_1}), k == 1 ? 2 : 0);
        end
        check("pre_rst_lo2", int'(lo_2), 1);
        rst_n = 1'b0;
        #1;
        check("arst_gates", int'({hi_1, lo_1, hi_2, lo_2}), 0);
        check("arst_fault", int'(fault), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("rst_rel_leg1", int'({hi_1, lo_1}), k == 6 ? 1 : 0);
            check("rst_rel_leg2", int'({hi_2, lo_2}), k == 6 ? 1 : 0);
        end
        repeat (4) @(negedge clk);

        // Dead band changed 2 -> 7 mid-DEAD: current gap stays 2, next uses 7.
        dead_time = 8'd2;
        pwm_1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("dt_chg", int'({hi_1, lo_1}), k == 1 ? 1 : (k == 4 ? 2 : 0));
            if (k == 2) dead_time = 8'd7;
        end
        repeat (6) @(negedge clk);
        leg1_edge(1'b0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
